// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// LfsrChecker (module lfsr_checker)
//
// Receive-side checker for the 8-bit LFSR byte generator.
// next(x) = {x[4]^x[3]^x[2]^x[0], x[7:1]}.
// The checker seeds itself from any non-zero byte. It declares lock after
// LOCK_CNT correct predictions in a row. While locked it keeps predicting on
// its own, counts mismatching bytes, and drops back to hunting after
// LOSS_CNT consecutive misses.
//
// Optional feature macro: LFSR_CHK_SEG_EN
//   defined   -> hout_o is a registered active-low hex decode of err_cnt[7:0]
//   undefined -> no decoder is built; hout_o is tied to all segments off
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous reset, active-low
//   valid_in_i  data_in_i is sampled this cycle
//   data_in_i   received LFSR byte
//   locked_o    high while in LOCKED
//   match_o     one-cycle pulse: last sampled byte equalled the prediction
//   err_cnt_o   saturating count of mismatches seen while LOCKED
//   expected_o  prediction for the next valid byte
//   hout_o      two active-low 7-segment digits {high nibble, low nibble},
//               each digit ordered {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module lfsr_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_in_i,
    input  logic [7:0]       data_in_i,
    output logic             locked_o,
    output logic             match_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [7:0]       expected_o,
    output logic [13:0]      hout_o
);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_e;

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

    state_e           state_q, state_d;
    logic [7:0]       expected_q, expected_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             match_q, match_d;

    function automatic logic [7:0] lfsrNext(input logic [7:0] x);
        return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
    endfunction

    // State register for the checker; everything returns to its idle
    // values as soon as reset is asserted, without waiting for a clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HUNT;
            expected_q <= 8'h00;
            run_q      <= 4'd0;
            miss_q     <= 4'd0;
            err_q      <= '0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            run_q      <= run_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            match_q    <= match_d;
        end
    end

    // Next-state logic. Only valid cycles act; otherwise everything holds
    // and the match pulse is dropped.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        run_d      = run_q;
        miss_d     = miss_q;
        err_d      = err_q;
        match_d    = 1'b0;

        if (valid_in_i) begin
            unique case (state_q)
                HUNT: begin
                    // All-zero is the stuck state and can never seed.
                    if (data_in_i != 8'h00) begin
                        expected_d = lfsrNext(data_in_i);
                        run_d      = 4'd0;
                        state_d    = VERIFY;
                    end
                end

                VERIFY: begin
                    if (data_in_i == expected_q) begin
                        match_d    = 1'b1;
                        expected_d = lfsrNext(data_in_i);
                        run_d      = run_q + 4'd1;
                        if (run_q + 4'd1 == LOCK_N) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else if (data_in_i != 8'h00) begin
                        // Wrong prediction: the received byte becomes the new seed.
                        expected_d = lfsrNext(data_in_i);
                        run_d      = 4'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end

                LOCKED: begin
                    // Flywheel: predictions advance from our own copy of the
                    // sequence, never from the received byte.
                    expected_d = lfsrNext(expected_q);
                    if (data_in_i == expected_q) begin
                        match_d = 1'b1;
                        miss_d  = 4'd0;
                    end else begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        miss_d = miss_q + 4'd1;
                        if (miss_q + 4'd1 == LOSS_N) begin
                            state_d = HUNT;
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    assign locked_o   = (state_q == LOCKED);
    assign match_o    = match_q;
    assign err_cnt_o  = err_q;
    assign expected_o = expected_q;

`ifdef LFSR_CHK_SEG_EN
    logic [13:0] hout_q;

    // Active-low hex glyph, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Display register trails err_cnt by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hout_q <= 14'h3FFF;
        end else begin
            hout_q <= {hexSeg(err_q[7:4]), hexSeg(err_q[3:0])};
        end
    end

    assign hout_o = hout_q;
`else
    assign hout_o = 14'h3FFF;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// Testbench for lfsr_checker. Directed scenarios plus randomized traffic,
// checked through a scoreboard fed by a behavioural model of the checker.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int ERR_W    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid;
    logic [7:0]       data;
    logic             locked;
    logic             match;
    logic [ERR_W-1:0] errCnt;
    logic [7:0]       expected;
    logic [13:0]      hout;

    lfsr_checker #(
        .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT),
        .ERR_W   (ERR_W)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .valid_in_i(valid),
        .data_in_i (data),
        .locked_o  (locked),
        .match_o   (match),
        .err_cnt_o (errCnt),
        .expected_o(expected),
        .hout_o    (hout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             locked;
        logic             match;
        logic [ERR_W-1:0] err;
        logic [7:0]       expected;
        logic [13:0]      hout;
    } expect_t;

    expect_t scb[$];
    int checks = 0;
    int errors = 0;

    // Active-low glyphs {g,f,e,d,c,b,a} indexed by digit value.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Behavioural model state: phase 0 = hunting, 1 = verifying, 2 = locked.
    int         mPhase;
    logic [7:0] mExp;
    int         mRun;
    int         mMiss;
    int         mErr;
    logic [13:0] mHout;

    // Sequence step in arithmetic form: shift right, feedback bit is the
    // parity of taps 4,3,2,0 placed at weight 128.
    function automatic logic [7:0] lfsrStep(input logic [7:0] x);
        int v;
        v = int'(x) / 2;
        if (^(x & 8'h1D)) v = v + 128;
        return 8'(v);
    endfunction

    task automatic resetModel();
        mPhase = 0;
        mExp   = 8'h00;
        mRun   = 0;
        mMiss  = 0;
        mErr   = 0;
        mHout  = 14'h3FFF;
    endtask

    task automatic modelStep(input logic v, input logic [7:0] d);
        expect_t e;
        logic    hit;
        hit = 1'b0;
`ifdef LFSR_CHK_SEG_EN
        mHout = {GLYPH[(mErr / 16) % 16], GLYPH[mErr % 16]};
`else
        mHout = 14'h3FFF;
`endif
        if (v) begin
            if (mPhase == 2) begin
                hit = (d == mExp);
                if (hit) mMiss = 0;
                else begin
                    if (mErr < (1 << ERR_W) - 1) mErr = mErr + 1;
                    mMiss = mMiss + 1;
                    if (mMiss == LOSS_CNT) mPhase = 0;
                end
                mExp = lfsrStep(mExp);
            end else if (mPhase == 1 && d == mExp) begin
                hit  = 1'b1;
                mRun = mRun + 1;
                mExp = lfsrStep(d);
                if (mRun == LOCK_CNT) begin
                    mPhase = 2;
                    mMiss  = 0;
                end
            end else if (d != 8'h00) begin
                mExp   = lfsrStep(d);
                mRun   = 0;
                mPhase = 1;
            end else begin
                mPhase = 0;
            end
        end
        e.locked   = (mPhase == 2);
        e.match    = hit;
        e.err      = ERR_W'(mErr);
        e.expected = mExp;
        e.hout     = mHout;
        scb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus and record the model's prediction.
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        @(negedge clk);
        valid = v;
        data  = d;
        modelStep(v, d);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_locked"}, 32'(locked), 32'd0);
        checkOutput({tag, "_match"}, 32'(match), 32'd0);
        checkOutput({tag, "_err"}, 32'(errCnt), 32'd0);
        checkOutput({tag, "_expected"}, 32'(expected), 32'h00);
        checkOutput({tag, "_hout"}, 32'(hout), 32'h3FFF);
    endtask

    // Assert reset between clock edges and check it takes effect at once.
    task automatic midReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        checkResetValues("midreset");
        resetModel();
        scb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lockFrom01();
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h80);
        applyStimulus(1'b1, 8'h40);
        applyStimulus(1'b1, 8'h20);
        applyStimulus(1'b1, 8'h10);
    endtask

    // Monitor: after each clock edge compare the DUT against the oldest
    // outstanding prediction.
    always @(posedge clk) begin
        expect_t e;
        #1;
        if (scb.size() > 0) begin
            e = scb.pop_front();
            checkOutput("scb_locked", 32'(locked), 32'(e.locked));
            checkOutput("scb_match", 32'(match), 32'(e.match));
            checkOutput("scb_err", 32'(errCnt), 32'(e.err));
            checkOutput("scb_expected", 32'(expected), 32'(e.expected));
            checkOutput("scb_hout", 32'(hout), 32'(e.hout));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        resetModel();
        #3;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Lock acquisition from seed 01.
        lockFrom01();
        settle();
        checkOutput("lock_locked", 32'(locked), 32'd1);
        checkOutput("lock_expected", 32'(expected), 32'h88);
        checkOutput("lock_match", 32'(match), 32'd1);
        checkOutput("lock_err", 32'(errCnt), 32'd0);

        // Flywheel: a wrong byte does not resync the prediction.
        applyStimulus(1'b1, 8'h00);
        settle();
        checkOutput("fly_err", 32'(errCnt), 32'd1);
        checkOutput("fly_match", 32'(match), 32'd0);
        checkOutput("fly_expected", 32'(expected), 32'hC4);
        applyStimulus(1'b1, 8'hC4);
        settle();
        checkOutput("fly_match2", 32'(match), 32'd1);
        checkOutput("fly_locked", 32'(locked), 32'd1);

        // Loss of lock after three consecutive misses.
        applyStimulus(1'b1, 8'h55);
        applyStimulus(1'b1, 8'h55);
        settle();
        checkOutput("loss_still_locked", 32'(locked), 32'd1);
        applyStimulus(1'b1, 8'h55);
        settle();
        checkOutput("loss_locked", 32'(locked), 32'd0);
        checkOutput("loss_err", 32'(errCnt), 32'd4);
        applyStimulus(1'b1, 8'h01);
        settle();
        checkOutput("loss_reseed_expected", 32'(expected), 32'h80);
        checkOutput("loss_reseed_locked", 32'(locked), 32'd0);

        // Zero bytes never seed.
        midReset();
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h00);
        settle();
        checkOutput("zero_expected", 32'(expected), 32'h00);
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h80);
        settle();
        checkOutput("zero_expected2", 32'(expected), 32'h40);
        checkOutput("zero_locked", 32'(locked), 32'd0);

        // Idle cycles hold state.
        applyStimulus(1'b0, 8'h77);
        applyStimulus(1'b0, 8'h40);

`ifdef LFSR_CHK_SEG_EN
        // 26 errors -> display "1A".
        midReset();
        for (int i = 0; i < 9; i++) begin
            lockFrom01();
            for (int k = 0; k < ((i < 8) ? 3 : 2); k++) applyStimulus(1'b1, 8'h00);
        end
        applyStimulus(1'b0, 8'h00);
        settle();
        checkOutput("seg_err", 32'(errCnt), 32'h1A);
        checkOutput("seg_hout", 32'(hout), 32'({7'b1111001, 7'b0001000}));
`endif

        // Saturation: 300 misses while repeatedly relocking.
        midReset();
        for (int i = 0; i < 100; i++) begin
            lockFrom01();
            for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'h00);
        end
        settle();
        checkOutput("sat_err", 32'(errCnt), 32'hFF);
        checkOutput("sat_locked", 32'(locked), 32'd0);

        // Reset while locked with a full error count.
        lockFrom01();
        settle();
        checkOutput("prereset_locked", 32'(locked), 32'd1);
        midReset();

        // Randomized traffic: mostly correct predictions, some noise and idles.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 11));
            if (r == 0) applyStimulus(1'b0, 8'($urandom));
            else if (r <= 7) applyStimulus(1'b1, mExp);
            else if (r == 8) applyStimulus(1'b1, 8'h00);
            else applyStimulus(1'b1, 8'($urandom));
        end

        applyStimulus(1'b0, 8'h00);
        settle();
        settle();
        checkOutput("scb_drained", 32'(scb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 8-bit LFSR generator. It samples a byte stream produced by that generator, self-synchronises to the sequence from any non-zero byte, and declares lock after a run of correct predictions. Once locked it keeps predicting on its own, counts mismatching bytes, and drops lock after repeated consecutive misses. The error count can optionally drive the board's two-digit seven-segment display.

## Interface
- LOCK_CNT, default 4: consecutive correct predictions required to declare lock (1..15).
- LOSS_CNT, default 3: consecutive mismatches in LOCKED that force a return to HUNT (1..15).
- ERR_W, default 8: width of the error counter (8..16).
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low.
- valid_in  input  1  data_in is sampled on this cycle.
- data_in  input  8  received LFSR byte.
- locked  output  1  high while in LOCKED.
- match  output  1  one-cycle pulse: the last sampled byte equalled the prediction.
- err_cnt  output  ERR_W  saturating count of mismatches seen while LOCKED.
- expected  output  8  prediction for the next valid byte.
- hout  output  14  active-low segments, err_cnt[7:0]: [6:0] low nibble, [13:7] high nibble.

## Operation
- Sequence definition, identical to the generator: next(x) = {x[4]^x[3]^x[2]^x[0], x[7:1]}.
- All-zero is the stuck state and is never used as a seed.
- States: HUNT, VERIFY, LOCKED. Only cycles with valid_in=1 act; otherwise all state holds and match=0.
- HUNT:
  - data_in!=0: expected<=next(data_in), run<=0, go to VERIFY.
  - data_in==0: stay in HUNT.
- VERIFY, data_in==expected: match pulses, expected<=next(data_in), run<=run+1. When run+1==LOCK_CNT, go to LOCKED and clear miss.
- VERIFY, data_in!=expected: reseed as in HUNT, including the zero rule. A zero byte returns to HUNT. err_cnt is not touched.
- LOCKED, data_in==expected: match pulses, miss<=0, expected<=next(expected).
- LOCKED, data_in!=expected:
  - err_cnt+1, saturating at all-ones.
  - miss+1; expected<=next(expected) (flywheel: the received byte is never used to resync).
  - When miss+1==LOSS_CNT, go to HUNT. err_cnt is kept.
- err_cnt clears only on reset.
- Hex encoding for hout: 0-9 and A-F, segment order {g,f,e,d,c,b,a}, active-low.

## Timing
- All outputs registered. A byte sampled at edge N is reflected in locked, match, err_cnt and expected after edge N.
- Reset values: state=HUNT, locked=0, match=0, err_cnt=0, expected=8'h00, run=0, miss=0, hout=14'h3FFF (all segments off).
- Reset asserted mid-sequence aborts immediately to the reset values. The first valid byte after release is treated as a HUNT seed.
- Back-to-back valid bytes are supported at one per clock with no bubbles.
- Timing from the first valid byte: lock asserts LOCK_CNT+1 valid bytes after it. Loss asserts on the LOSS_CNT-th consecutive miss.

## Configuration
- LFSR_CHK_SEG_EN defined: hout is the registered hex decode of err_cnt[7:0] and updates one cycle after err_cnt.
- LFSR_CHK_SEG_EN undefined: the decoder is not built and hout is tied to 14'h3FFF. All other behaviour is unchanged.

## Test plan
- Lock acquisition: reset, then valid bytes 01,80,40,20,10. locked=1 after the 10 edge, match pulsed on each of 80,40,20,10, expected=88, err_cnt=0.
- Zero seed: in HUNT, send 00,00,01,80. State stays HUNT through the zeros; expected=40 after 80; locked=0.
- Flywheel error:
  - Stimulus: locked at expected=88, send 00, then C4.
  - After 00: err_cnt=1, match=0, expected=C4.
  - After C4: match=1, err_cnt=1, locked stays 1.
- Loss of lock (LOSS_CNT=3): locked, send three wrong bytes. locked=0 after the third, err_cnt=3, state HUNT. Next byte 01 enters VERIFY.
- Saturation and reset:
  - Force ERR_W=8 and 300 mismatches while repeatedly relocking. err_cnt holds at FF.
  - Assert rst mid-stream: all outputs return to their reset values without waiting for a clock edge.
- Display (LFSR_CHK_SEG_EN defined): err_cnt=8'h1A gives hout[6:0]=7'b0001000 (A) and hout[13:7]=7'b1111001 (1). With the macro undefined, hout=3FFF always.
